// File: rtl/alu4_wide_seq.sv
// Multi-nibble sequencer for a shared 4-bit ALU: one wide request in, LSB-first nibble passes, one wide response out.
// Define ALU4_SEQ_B2B_EN to let a new request be accepted in the same edge that retires the response.
module alu4_wide_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic [3:0]           req_sel,
  input  logic                 req_mode,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_f,
  output logic                 rsp_cout,
  output logic                 rsp_zero,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_sel,
  output logic                 alu_mode,
  output logic                 alu_cin,
  input  logic [3:0]           alu_f,
  input  logic                 alu_cout,
  output logic [1:0]           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the sender holds its payload stable from valid until that edge.

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            accept;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_q, b_q, res;
  logic [3:0]      sel_q;
  logic            mode_q, cin_q, carry_reg;

  assign state_dbg = state;
  assign rsp_valid = (state == DONE);
  assign rsp_f     = res;
  assign rsp_cout  = carry_reg;
  assign rsp_zero  = (res == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    req_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
`ifdef ALU4_SEQ_B2B_EN
        req_ready = rsp_ready;
        if (rsp_ready) begin
          if (req_valid) begin
            accept     = 1'b1;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
`else
        if (rsp_ready) state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
    // Ready is withheld while reset is asserted, even though the state already reads IDLE.
    if (!rst_n) begin
      req_ready = 1'b0;
      accept    = 1'b0;
    end
  end

  always_comb begin
    alu_a    = 4'd0;
    alu_b    = 4'd0;
    alu_sel  = 4'd0;
    alu_mode = 1'b0;
    alu_cin  = 1'b0;
    if (state == RUN) begin
      alu_a    = a_q[{idx, 2'b00} +: 4];
      alu_b    = b_q[{idx, 2'b00} +: 4];
      alu_sel  = sel_q;
      alu_mode = mode_q;
      alu_cin  = (idx == '0) ? cin_q : carry_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= 4'd0;
      mode_q    <= 1'b0;
      cin_q     <= 1'b0;
      res       <= '0;
      carry_reg <= 1'b0;
    end else if (accept) begin
      idx    <= '0;
      a_q    <= req_a;
      b_q    <= req_b;
      sel_q  <= req_sel;
      mode_q <= req_mode;
      cin_q  <= req_cin;
    end else if (state == RUN) begin
      // Carry is chained even in logic mode; the response reports whatever the ALU returned.
      res[{idx, 2'b00} +: 4] <= alu_f;
      carry_reg              <= alu_cout;
      if (idx != LAST) idx <= idx + 1'b1;
    end
  end

endmodule
